// File: rtl/long_chain_pkg.sv
// long_chain_pkg
//   Shared constants and types for the long-chain addition interface.
//   Used by the operand loader and by the adder tree it feeds, so both
//   sides agree on operand count and widths.
package long_chain_pkg;

  localparam int NUM_OPERANDS = 8;
  localparam int OPERAND_W    = 4;
  localparam int SUM_W        = 7;   // 8 x 15 = 120 fits in 7 bits
  localparam int IDX_W        = 3;   // log2(NUM_OPERANDS)

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2
  } loader_state_e;

  // Zero-extend one operand to the accumulator width.
  function automatic logic [SUM_W-1:0] widen_operand(input logic [OPERAND_W-1:0] v);
    return {{(SUM_W-OPERAND_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/long_chain_wait_timer.sv
// long_chain_wait_timer
//   Cycle counter bounding how long the loader waits for the adder tree.
//   Ports:
//     clk     - clock
//     rst     - asynchronous active-high reset
//     clr     - load the counter with zero (takes priority over en)
//     en      - count one cycle
//     expired - high during the TIMEOUT-th enabled cycle after a clear,
//               i.e. the last cycle the waiter may still be satisfied
module long_chain_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded one cycle early so the owner's state change lands exactly
  // TIMEOUT cycles after the first enabled cycle.
  assign expired = en & (count_q == LAST_COUNT);

endmodule

// File: rtl/long_chain_operand_loader.sv
// long_chain_operand_loader
//   Producer side of the long-chain addition interface. Packs eight serial
//   4-bit operands into the parallel operand bus, strobes s_vi, then waits
//   for the adder tree's final_sum and compares it with a local sum.
//   Ports:
//     clk, rst               - clock, asynchronous active-high reset
//     in_data/in_valid       - serial operand stream (input)
//     in_ready               - operand accepted this cycle when in_valid
//     input_val0..7          - parallel operands, slot k = k-th accepted
//     s_vi                   - one-cycle operands-valid strobe
//     final_sum/s_ld_valid   - result returned by the adder tree
//     sum_out/sum_valid      - last captured sum, one-cycle update pulse
//     mismatch               - captured sum differed from expected
//     timeout                - one-cycle pulse when the wait expires
//     busy                   - state is not COLLECT
module long_chain_operand_loader
  import long_chain_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OPERAND_W-1:0] input_val0,
  output logic [OPERAND_W-1:0] input_val1,
  output logic [OPERAND_W-1:0] input_val2,
  output logic [OPERAND_W-1:0] input_val3,
  output logic [OPERAND_W-1:0] input_val4,
  output logic [OPERAND_W-1:0] input_val5,
  output logic [OPERAND_W-1:0] input_val6,
  output logic [OPERAND_W-1:0] input_val7,
  output logic                 s_vi,
  input  logic [SUM_W-1:0]     final_sum,
  input  logic                 s_ld_valid,
  output logic [SUM_W-1:0]     sum_out,
  output logic                 sum_valid,
  output logic                 mismatch,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

  loader_state_e        state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [SUM_W-1:0]     expected_q;
  logic [OPERAND_W-1:0] slot_q [NUM_OPERANDS];
  logic [SUM_W-1:0]     sum_out_q;
  logic                 s_vi_q;
  logic                 sum_valid_q;
  logic                 mismatch_q;
  logic                 timeout_q;
  logic                 busy_q;

  logic                 accept;
  logic                 timer_expired;

  // Ready is the only combinational output; held low during reset so the
  // source cannot see a spurious accept.
  assign in_ready = ~rst & (state_q == ST_COLLECT);
  assign accept   = in_valid & in_ready;

  long_chain_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_ISSUE),
    .en      (state_q == ST_WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      expected_q  <= '0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        slot_q[i] <= '0;
      end
      sum_out_q   <= '0;
      s_vi_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      s_vi_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      timeout_q   <= 1'b0;

      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            slot_q[idx_q] <= in_data;
            idx_q         <= idx_q + IDX_W'(1);   // wraps to 0 after slot 7
            expected_q    <= expected_q + widen_operand(in_data);
            if (idx_q == LAST_IDX) begin
              state_q <= ST_ISSUE;
              s_vi_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          // A response on the expiry cycle still counts as a response.
          if (s_ld_valid) begin
            sum_out_q   <= final_sum;
            mismatch_q  <= (final_sum != expected_q);
            sum_valid_q <= 1'b1;
            expected_q  <= '0;
            state_q     <= ST_COLLECT;
            busy_q      <= 1'b0;
          end else if (timer_expired) begin
            timeout_q   <= 1'b1;
            expected_q  <= '0;
            state_q     <= ST_COLLECT;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_COLLECT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign input_val0 = slot_q[0];
  assign input_val1 = slot_q[1];
  assign input_val2 = slot_q[2];
  assign input_val3 = slot_q[3];
  assign input_val4 = slot_q[4];
  assign input_val5 = slot_q[5];
  assign input_val6 = slot_q[6];
  assign input_val7 = slot_q[7];

  assign s_vi      = s_vi_q;
  assign sum_out   = sum_out_q;
  assign sum_valid = sum_valid_q;
  assign mismatch  = mismatch_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_long_chain_operand_loader.sv
// Directed bench for long_chain_operand_loader. Main instance uses the
// default TIMEOUT of 16; a second instance with TIMEOUT = 4 covers the
// response-on-expiry-cycle case.
module tb_long_chain_operand_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance (TIMEOUT = 16)
  logic [3:0] in_data    = '0;
  logic       in_valid   = 1'b0;
  logic [6:0] final_sum  = '0;
  logic       s_ld_valid = 1'b0;
  logic       in_ready, s_vi, sum_valid, mismatch, timeout, busy;
  logic [3:0] iv0, iv1, iv2, iv3, iv4, iv5, iv6, iv7;
  logic [6:0] sum_out;

  // Second instance (TIMEOUT = 4)
  logic [3:0] in_data4    = '0;
  logic       in_valid4   = 1'b0;
  logic [6:0] final_sum4  = '0;
  logic       s_ld_valid4 = 1'b0;
  logic       in_ready4, s_vi4, sum_valid4, mismatch4, timeout4, busy4;
  logic [3:0] jv0, jv1, jv2, jv3, jv4, jv5, jv6, jv7;
  logic [6:0] sum_out4;

  int nvec = 0;
  int nerr = 0;

  long_chain_operand_loader #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
    .input_val0(iv0), .input_val1(iv1), .input_val2(iv2), .input_val3(iv3),
    .input_val4(iv4), .input_val5(iv5), .input_val6(iv6), .input_val7(iv7),
    .s_vi(s_vi), .final_sum(final_sum), .s_ld_valid(s_ld_valid),
    .sum_out(sum_out), .sum_valid(sum_valid), .mismatch(mismatch),
    .timeout(timeout), .busy(busy)
  );

  long_chain_operand_loader #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4),
    .input_val0(jv0), .input_val1(jv1), .input_val2(jv2), .input_val3(jv3),
    .input_val4(jv4), .input_val5(jv5), .input_val6(jv6), .input_val7(jv7),
    .s_vi(s_vi4), .final_sum(final_sum4), .s_ld_valid(s_ld_valid4),
    .sum_out(sum_out4), .sum_valid(sum_valid4), .mismatch(mismatch4),
    .timeout(timeout4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Sends 8 operands, nibble k of vals = operand k; returns just after
  // the 8th accept edge (the ISSUE cycle).
  task automatic send_set(input logic [31:0] vals);
    for (int k = 0; k < 8; k++) begin
      send_op(vals[4*k +: 4]);
    end
  endtask

  task automatic chk_slots(input string tag, input logic [31:0] vals);
    chk({tag, "_v0"}, 32'(iv0), 32'(vals[3:0]));
    chk({tag, "_v1"}, 32'(iv1), 32'(vals[7:4]));
    chk({tag, "_v2"}, 32'(iv2), 32'(vals[11:8]));
    chk({tag, "_v3"}, 32'(iv3), 32'(vals[15:12]));
    chk({tag, "_v4"}, 32'(iv4), 32'(vals[19:16]));
    chk({tag, "_v5"}, 32'(iv5), 32'(vals[23:20]));
    chk({tag, "_v6"}, 32'(iv6), 32'(vals[27:24]));
    chk({tag, "_v7"}, 32'(iv7), 32'(vals[31:28]));
  endtask

  task automatic send_op4(input logic [3:0] d);
    in_data4  = d;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
  endtask

  initial begin
    // ---------------- reset: asserted mid-clock, checked before any edge
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_vi", 32'(s_vi), 0);
    chk("rst_sum_out", 32'(sum_out), 0);
    chk("rst_sum_valid", 32'(sum_valid), 0);
    chk("rst_mismatch", 32'(mismatch), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_iv0", 32'(iv0), 0);
    chk("rst_iv7", 32'(iv7), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_busy", 32'(busy), 0);

    // ---------------- nominal set 0,5,6,7,8,9,2,2 -> 39
    send_set(32'h2298_7650);
    chk("nom_s_vi", 32'(s_vi), 1);
    chk("nom_in_ready_issue", 32'(in_ready), 0);
    chk("nom_busy", 32'(busy), 1);
    chk_slots("nom", 32'h2298_7650);
    tick();  // first WAIT cycle
    chk("nom_s_vi_one_cycle", 32'(s_vi), 0);
    chk("nom_in_ready_wait", 32'(in_ready), 0);
    final_sum  = 7'd39;
    s_ld_valid = 1'b1;
    tick();
    s_ld_valid = 1'b0;
    chk("nom_sum_valid", 32'(sum_valid), 1);
    chk("nom_sum_out", 32'(sum_out), 39);
    chk("nom_mismatch", 32'(mismatch), 0);
    chk("nom_in_ready_back", 32'(in_ready), 1);
    chk("nom_busy_back", 32'(busy), 0);
    tick();
    chk("nom_sum_valid_pulse", 32'(sum_valid), 0);
    chk("nom_slots_held", 32'(iv5), 9);

    // ---------------- gapped input, eight 15s -> expected 120, return 119
    for (int k = 0; k < 4; k++) send_op(4'd15);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap_in_ready", 32'(in_ready), 1);
      chk("gap_s_vi", 32'(s_vi), 0);
    end
    for (int k = 0; k < 4; k++) send_op(4'd15);
    chk("gap_s_vi", 32'(s_vi), 1);
    chk_slots("gap", 32'hFFFF_FFFF);
    tick();
    final_sum  = 7'd119;
    s_ld_valid = 1'b1;
    tick();
    s_ld_valid = 1'b0;
    chk("gap_sum_valid", 32'(sum_valid), 1);
    chk("gap_sum_out", 32'(sum_out), 119);
    chk("gap_mismatch", 32'(mismatch), 1);

    // ---------------- timeout after 16 WAIT cycles
    send_set(32'h1111_1111);
    chk("to_s_vi", 32'(s_vi), 1);
    // After k more edges: WAIT spans k=1..16, timeout visible at k=17.
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("to_early", 32'(timeout), 0);
      chk("to_busy_wait", 32'(busy), 1);
    end
    tick();
    chk("to_pulse", 32'(timeout), 1);
    chk("to_in_ready", 32'(in_ready), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_sum_out_kept", 32'(sum_out), 119);
    chk("to_mismatch_kept", 32'(mismatch), 1);
    chk("to_no_sum_valid", 32'(sum_valid), 0);
    tick();
    chk("to_pulse_one_cycle", 32'(timeout), 0);

    // ---------------- reset mid-collect, then 1..8 -> 36
    for (int k = 0; k < 5; k++) send_op(4'd9);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_iv0", 32'(iv0), 0);
    chk("mid_rst_sum_out", 32'(sum_out), 0);
    #2;
    rst = 1'b0;
    #1;
    send_set(32'h8765_4321);
    chk("mid_s_vi", 32'(s_vi), 1);
    chk_slots("mid", 32'h8765_4321);
    tick();
    final_sum  = 7'd36;
    s_ld_valid = 1'b1;
    tick();
    s_ld_valid = 1'b0;
    chk("mid_sum_valid", 32'(sum_valid), 1);
    chk("mid_sum_out", 32'(sum_out), 36);
    chk("mid_mismatch", 32'(mismatch), 0);

    // ---------------- stray s_ld_valid during COLLECT
    tick();
    final_sum  = 7'd99;
    s_ld_valid = 1'b1;
    tick();
    s_ld_valid = 1'b0;
    chk("stray_sum_valid", 32'(sum_valid), 0);
    chk("stray_sum_out", 32'(sum_out), 36);
    chk("stray_mismatch", 32'(mismatch), 0);
    chk("stray_busy", 32'(busy), 0);

    // ---------------- TIMEOUT=4: response on the exact expiry cycle
    for (int k = 0; k < 8; k++) send_op4(4'd3);
    chk("exp_s_vi", 32'(s_vi4), 1);
    // WAIT cycles after edges +1..+4; the 4th is the expiry cycle.
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("exp_wait_timeout", 32'(timeout4), 0);
    end
    tick();
    chk("exp_last_busy", 32'(busy4), 1);
    final_sum4  = 7'd24;
    s_ld_valid4 = 1'b1;
    tick();
    s_ld_valid4 = 1'b0;
    chk("exp_sum_valid", 32'(sum_valid4), 1);
    chk("exp_timeout", 32'(timeout4), 0);
    chk("exp_sum_out", 32'(sum_out4), 24);
    chk("exp_mismatch", 32'(mismatch4), 0);
    tick();
    chk("exp_timeout_after", 32'(timeout4), 0);
    chk("exp_in_ready", 32'(in_ready4), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
